rtc_core: RTL and testbench

//  Parametrised hh:mm:ss real-time clock core with debounced two-key time setting.

---
 rtl/rtc_core.sv | 201 ++++++++++++++++++++
 tb/tb_rtc_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_core.sv
// rtc_core: hh:mm:ss real-time clock core with debounced two-key time setting.
// Optional feature macro: RTC_CORE_ALARM_EN (alarm registers, AL_HOUR/AL_MIN modes, o_alarm_out).
// Ports:
//   i_clock      system clock
//   i_reset_n    asynchronous active-low reset
//   i_key_mode   raw mode key (async, active high)
//   i_key_inc    raw increment key (async, active high)
//   i_run_en     1 = time advances in RUN, 0 = frozen
//   o_second     0..59
//   o_minute     0..59
//   o_hour       0..HOUR_MAX
//   o_mode       0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 AL_HOUR, 4 AL_MIN
//   o_sec_pulse  1-cycle strobe per counted second
//   o_day_pulse  1-cycle strobe when hour wraps HOUR_MAX->0
//   o_blink      first half of each second while editing
//   o_data_show  {1'b1, hour, minute} (alarm registers in AL modes)
//   o_alarm_out  alarm active level (alarm build only)
module rtc_core #(
  parameter int PRESCALE     = 65536,
  parameter int DEBOUNCE_DIV = 1024,
  parameter int DEBOUNCE_LEN = 4,
  parameter int HOUR_MAX     = 23
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_key_mode,
  input  logic        i_key_inc,
  input  logic        i_run_en,
  output logic [5:0]  o_second,
  output logic [5:0]  o_minute,
  output logic [4:0]  o_hour,
  output logic [2:0]  o_mode,
  output logic        o_sec_pulse,
  output logic        o_day_pulse,
  output logic        o_blink,
  output logic [11:0] o_data_show
`ifdef RTC_CORE_ALARM_EN
  ,output logic       o_alarm_out
`endif
);
  localparam int PW = $clog2(PRESCALE);
  localparam int DW = DEBOUNCE_DIV > 1 ? $clog2(DEBOUNCE_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_HALF = PW'(PRESCALE / 2);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_DIV - 1);
  localparam logic [2:0] M_RUN = 3'd0;
  localparam logic [2:0] M_SH  = 3'd1;
  localparam logic [2:0] M_SM  = 3'd2;
  localparam logic [2:0] M_AH  = 3'd3;
  localparam logic [2:0] M_AM  = 3'd4;
`ifdef RTC_CORE_ALARM_EN
  localparam logic [2:0] M_SM_NX = M_AH;
  localparam logic [2:0] M_LAST  = M_AM;
`else
  localparam logic [2:0] M_SM_NX = M_RUN;
  localparam logic [2:0] M_LAST  = M_SM;
`endif

  logic [PW-1:0]           r_presc;
  logic [5:0]              r_sec, r_min;
  logic [4:0]              r_hour;
  logic                    r_sec_pulse, r_day_pulse;
  logic [2:0]              r_mode, w_mode_nx;
  logic [1:0]              r_sync1, r_sync2, r_lvl, r_lvl_q;
  logic [DEBOUNCE_LEN-1:0] r_sh_mode, r_sh_inc;
  logic [DW-1:0]           r_div;
  logic                    w_sample, w_press_mode, w_press_inc, w_inc;
  logic                    w_run, w_edit, w_legal, w_enter_set, w_tick;
  logic                    w_sec_wrap, w_min_wrap, w_hour_wrap;
  logic [5:0]              w_sec_inc, w_min_inc, w_disp_min;
  logic [4:0]              w_hour_inc, w_disp_hour;

  // Key conditioning: bit 0 = mode key, bit 1 = inc key.
  assign w_sample = r_div == D_LAST;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_div     <= '0;
      r_sh_mode <= '0;
      r_sh_inc  <= '0;
      r_lvl     <= '0;
      r_lvl_q   <= '0;
    end else begin
      r_sync1 <= {i_key_inc, i_key_mode};
      r_sync2 <= r_sync1;
      r_div   <= w_sample ? '0 : r_div + DW'(1);
      if (w_sample) begin
        r_sh_mode <= {r_sh_mode[DEBOUNCE_LEN-2:0], r_sync2[0]};
        r_sh_inc  <= {r_sh_inc[DEBOUNCE_LEN-2:0], r_sync2[1]};
      end
      // Hysteresis: set on all-ones, clear on all-zeros, otherwise hold.
      r_lvl[0] <= (&r_sh_mode) | (r_lvl[0] & (|r_sh_mode));
      r_lvl[1] <= (&r_sh_inc) | (r_lvl[1] & (|r_sh_inc));
      r_lvl_q  <= r_lvl;
    end
  end
  assign w_press_mode = r_lvl[0] & ~r_lvl_q[0];
  assign w_press_inc  = r_lvl[1] & ~r_lvl_q[1];
  assign w_inc        = w_press_inc & ~w_press_mode;

  // Mode FSM: state register / next state / outputs.
  assign w_legal = r_mode <= M_LAST;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_mode <= M_RUN;
    else r_mode <= w_mode_nx;
  end
  always_comb begin
    w_mode_nx = r_mode;
    if (!w_legal) w_mode_nx = M_RUN;
    else if (w_press_mode)
      w_mode_nx = (r_mode == M_RUN) ? M_SH :
                  (r_mode == M_SH)  ? M_SM :
                  (r_mode == M_SM)  ? M_SM_NX :
                  (r_mode == M_AH)  ? M_AM : M_RUN;
  end
  always_comb begin
    w_run   = r_mode == M_RUN;
    w_edit  = w_legal && !w_run;
    o_blink = w_edit && (r_presc < P_HALF);
  end

  // Entering SET_HOUR clears the second and prescaler and swallows a coincident tick.
  assign w_enter_set = w_run & w_press_mode;
  assign w_tick      = w_run & i_run_en & (r_presc == P_LAST) & ~w_enter_set;
  assign w_sec_wrap  = r_sec == 6'd59;
  assign w_min_wrap  = r_min == 6'd59;
  assign w_hour_wrap = r_hour == 5'(HOUR_MAX);
  assign w_sec_inc   = w_sec_wrap ? '0 : r_sec + 6'd1;
  assign w_min_inc   = w_min_wrap ? '0 : r_min + 6'd1;
  assign w_hour_inc  = w_hour_wrap ? '0 : r_hour + 5'd1;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_presc     <= '0;
      r_sec       <= '0;
      r_min       <= '0;
      r_hour      <= '0;
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
    end else begin
      // Outside RUN the prescaler free-runs purely to drive blink.
      if (w_enter_set) r_presc <= '0;
      else if (!w_run || i_run_en) r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
      if (w_enter_set) r_sec <= '0;
      else if (w_tick) begin
        r_sec <= w_sec_inc;
        if (w_sec_wrap) r_min <= w_min_inc;
        if (w_sec_wrap && w_min_wrap) r_hour <= w_hour_inc;
      end
      else if (w_inc && r_mode == M_SH) r_hour <= w_hour_inc;
      else if (w_inc && r_mode == M_SM) r_min <= w_min_inc;
      r_sec_pulse <= w_tick;
      r_day_pulse <= w_tick & w_sec_wrap & w_min_wrap & w_hour_wrap;
    end
  end

`ifdef RTC_CORE_ALARM_EN
  logic [4:0] r_al_hour;
  logic [5:0] r_al_min, r_al_cnt;
  logic       r_al_on, w_hit, w_show_al;
  assign w_show_al = r_mode == M_AH || r_mode == M_AM;
  // Match against the time this tick is about to load, where second becomes 0.
  assign w_hit = w_tick && w_sec_wrap && w_min_inc == r_al_min &&
                 (w_min_wrap ? w_hour_inc : r_hour) == r_al_hour;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_al_hour <= '0;
      r_al_min  <= '0;
      r_al_cnt  <= '0;
      r_al_on   <= 1'b0;
    end else begin
      if (w_inc && r_mode == M_AH) r_al_hour <= (r_al_hour == 5'(HOUR_MAX)) ? '0 : r_al_hour + 5'd1;
      if (w_inc && r_mode == M_AM) r_al_min <= (r_al_min == 6'd59) ? '0 : r_al_min + 6'd1;
      if (w_press_mode || w_press_inc) r_al_on <= 1'b0;
      else if (w_hit) begin
        r_al_on  <= 1'b1;
        r_al_cnt <= '0;
      end
      else if (w_tick && r_al_on) begin
        r_al_cnt <= r_al_cnt + 6'd1;
        if (r_al_cnt == 6'd59) r_al_on <= 1'b0;
      end
    end
  end
  assign w_disp_hour = w_show_al ? r_al_hour : r_hour;
  assign w_disp_min  = w_show_al ? r_al_min : r_min;
  assign o_alarm_out = r_al_on;
`else
  assign w_disp_hour = r_hour;
  assign w_disp_min  = r_min;
`endif

  assign o_second    = r_sec;
  assign o_minute    = r_min;
  assign o_hour      = r_hour;
  assign o_mode      = r_mode;
  assign o_sec_pulse = r_sec_pulse;
  assign o_day_pulse = r_day_pulse;
  assign o_data_show = {1'b1, w_disp_hour, w_disp_min};
endmodule

// File: tb/tb_rtc_core.sv
// tb_rtc_core: scoreboard bench for rtc_core (24 h instance plus a 12 h instance on the same keys).
module tb_rtc_core;
  logic        clk = 1'b0, rst_n = 1'b0, k_mode = 1'b0, k_inc = 1'b0, run_en = 1'b0;
  logic [5:0]  sec, min, sec12, min12;
  logic [4:0]  hour, hour12;
  logic [2:0]  mode, mode12;
  logic        sec_pulse, day_pulse, blink, sec_pulse12, day_pulse12, blink12;
  logic [11:0] show, show12;
`ifdef RTC_CORE_ALARM_EN
  logic        alarm, alarm12;
`endif
  int          n_chk = 0, n_fail = 0;
  logic [17:0] sbq[$];
  logic [17:0] sb_exp;
  int          mh = 0, mm = 0, ms = 0;

  always #5 clk = ~clk;

  rtc_core #(.PRESCALE(4), .DEBOUNCE_DIV(1), .DEBOUNCE_LEN(4), .HOUR_MAX(23)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_key_mode(k_mode), .i_key_inc(k_inc), .i_run_en(run_en),
    .o_second(sec), .o_minute(min), .o_hour(hour), .o_mode(mode), .o_sec_pulse(sec_pulse),
    .o_day_pulse(day_pulse), .o_blink(blink), .o_data_show(show)
`ifdef RTC_CORE_ALARM_EN
    , .o_alarm_out(alarm)
`endif
  );

  rtc_core #(.PRESCALE(4), .DEBOUNCE_DIV(1), .DEBOUNCE_LEN(4), .HOUR_MAX(11)) dut12 (
    .i_clock(clk), .i_reset_n(rst_n), .i_key_mode(k_mode), .i_key_inc(k_inc), .i_run_en(run_en),
    .o_second(sec12), .o_minute(min12), .o_hour(hour12), .o_mode(mode12), .o_sec_pulse(sec_pulse12),
    .o_day_pulse(day_pulse12), .o_blink(blink12), .o_data_show(show12)
`ifdef RTC_CORE_ALARM_EN
    , .o_alarm_out(alarm12)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference time model for the 24 h instance; one entry per expected second.
  task automatic push_secs(input int n);
    logic day;
    for (int i = 0; i < n; i++) begin
      day = 1'b0;
      if (ms == 59) begin
        ms = 0;
        if (mm == 59) begin
          mm = 0;
          if (mh == 23) begin
            mh = 0;
            day = 1'b1;
          end else mh++;
        end else mm++;
      end else ms++;
      sbq.push_back({day, 5'(mh), 6'(mm), 6'(ms)});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sec_pulse) begin
        if (sbq.size() == 0) check("sb_extra", {31'd0, sec_pulse}, 32'd0);
        else begin
          sb_exp = sbq.pop_front();
          check("sb_time", {14'd0, day_pulse, hour, min, sec}, {14'd0, sb_exp});
        end
      end
      else if (day_pulse) check("day_stray", {31'd0, day_pulse}, 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    k_mode = m;
    k_inc  = i;
    step(8);
    k_mode = 1'b0;
    k_inc  = 1'b0;
    step(10);
  endtask

  task automatic incs(input int n);
    repeat (n) press(1'b0, 1'b1);
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && sbq.size() != 0; i++) step(1);
    check("sb_drain", sbq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    step(3);
    check("rst_sec", sec, 0);
    check("rst_min", min, 0);
    check("rst_hour", hour, 0);
    check("rst_mode", mode, 0);
    check("rst_secp", sec_pulse, 0);
    check("rst_dayp", day_pulse, 0);
    check("rst_blink", blink, 0);
    check("rst_show", show, 12'h800);
`ifdef RTC_CORE_ALARM_EN
    check("rst_alarm", alarm, 0);
`endif
    run_en = 1'b1;
    rst_n  = 1'b1;
    push_secs(60);
    step(240);
    check("t1_left", sbq.size(), 0);
    check("t1_sec", sec, 0);
    check("t1_min", min, 1);
    check("t1_show", show, 12'h801);

    run_en = 1'b0;
    step(100);
    check("frz_sec", sec, 0);
    check("frz_min", min, 1);
    check("frz_hour", hour, 0);

    run_en = 1'b1;
    push_secs(5);
    step(20);
    check("run5_left", sbq.size(), 0);
    check("run5_sec", sec, 5);
    run_en = 1'b0;

    k_mode = 1'b1;
    step(2);
    k_mode = 1'b0;
    step(10);
    check("glitch_mode", mode, 0);

    press(1'b1, 1'b0);
    check("sh_mode", mode, 1);
    check("sh_sec", sec, 0);
    check("sh_show", show, 12'h801);
    nb = 0;
    repeat (8) begin
      step(1);
      nb += int'(blink);
    end
    check("sh_blink", nb, 4);

    incs(23);
    check("sh_hour23", hour, 23);
    check("sh12_hour11", hour12, 11);
    check("sh_min_keep", min, 1);
    incs(1);
    check("sh_hour_wrap", hour, 0);
    check("sh12_hour_wrap", hour12, 0);
    check("sh_min_keep2", min, 1);
    incs(23);

    press(1'b1, 1'b1);
    check("both_mode", mode, 2);
    check("both_hour", hour, 23);

    incs(58);
    check("sm_min59", min, 59);
    incs(1);
    check("sm_min_wrap", min, 0);
    check("sm_hour_keep", hour, 23);
    incs(59);

`ifdef RTC_CORE_ALARM_EN
    press(1'b1, 1'b0);
    check("ah_mode", mode, 3);
    check("ah_show", show, 12'h800);
    press(1'b1, 1'b0);
    check("am_mode", mode, 4);
    incs(2);
    check("am_show", show, 12'h802);
    check("am_min_keep", min, 59);
    press(1'b1, 1'b0);
`else
    press(1'b1, 1'b0);
`endif
    check("run_mode", mode, 0);
    check("run_time", {hour, min, sec}, {5'd23, 6'd59, 6'd0});
    check("run12_hour", hour12, 11);

    press(1'b0, 1'b1);
    check("run_inc_ign", {hour, min, sec}, {5'd23, 6'd59, 6'd0});

    mh = 23; mm = 59; ms = 0;
    run_en = 1'b1;
    push_secs(60);
    drain(248);
    run_en = 1'b0;
    check("mid_time", {hour, min, sec}, 0);
    check("mid_dayp", day_pulse, 1);
    check("mid12_time", {hour12, min12, sec12}, 0);
    check("mid12_dayp", day_pulse12, 1);
    step(1);
    check("mid_dayp_end", day_pulse, 0);
    check("mid12_dayp_end", day_pulse12, 0);

`ifdef RTC_CORE_ALARM_EN
    run_en = 1'b1;
    push_secs(119);
    drain(119 * 4 + 8);
    check("al_before", alarm, 0);
    push_secs(1);
    drain(12);
    run_en = 1'b0;
    check("al_rise", alarm, 1);
    check("al_time", {hour, min, sec}, {5'd0, 6'd2, 6'd0});
    press(1'b0, 1'b1);
    check("al_clear", alarm, 0);
    check("al_time_keep", {hour, min, sec}, {5'd0, 6'd2, 6'd0});
`endif

    k_mode = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    check("arst_time", {hour, min, sec}, 0);
    check("arst_show", show, 12'h800);
    k_mode = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(12);
    check("arst_mode", mode, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
